// File: rtl/vram_port_arbiter.sv
// Single-port scheduler for the VRAM system-clock port: display reads, draw read/write
// and a full-frame clear engine share one registered address/data/we port.
module vram_port_arbiter #(
  parameter int TOTAL_BYTES  = 230400,
  parameter int ADDR_W       = 18,
  parameter int STARVE_LIMIT = 15,
  parameter int STARVE_W     = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic              DISP_GNT,
  output logic              DISP_RVALID,
  output logic [7:0]        DISP_RDATA,
  input  logic              DRAW_REQ,
  input  logic              DRAW_WE,
  input  logic [ADDR_W-1:0] DRAW_ADDR,
  input  logic [7:0]        DRAW_DATA,
  output logic              DRAW_GNT,
  output logic              DRAW_RVALID,
  output logic [7:0]        DRAW_RDATA,
  input  logic              CLEAR_START,
  input  logic [7:0]        CLEAR_VALUE,
  output logic              CLEAR_BUSY,
  output logic              CLEAR_DONE,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic [7:0]        VRAM_DATA,
  output logic              VRAM_WE,
  input  logic [7:0]        VRAM_Q
);

  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(TOTAL_BYTES - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t              state;
  state_t              next_state;
  logic [STARVE_W-1:0] starve;
  logic [ADDR_W-1:0]   clear_addr;
  logic [7:0]          clear_value;
  logic                clear_done;
  logic                disp_gnt;
  logic                draw_gnt;
  logic                clear_gnt;
  logic                clear_last;
  logic [1:0]          tag_s1;
  logic [1:0]          tag_s2;

  assign clear_last = clear_gnt && (clear_addr == LAST_ADDR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ARB;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB:     if (CLEAR_START) next_state = CLEAR;
      CLEAR:   if (clear_last)  next_state = ARB;
      default: next_state = ARB;
    endcase
  end

  // Grants are gated by reset so every output reads 0 while RST_N is low.
  always_comb begin
    disp_gnt  = 1'b0;
    draw_gnt  = 1'b0;
    clear_gnt = 1'b0;
    if (RST_N) begin
      case (state)
        ARB: begin
          if (DRAW_REQ && (starve == STARVE_MAX)) draw_gnt = 1'b1;
          else if (DISP_REQ)                      disp_gnt = 1'b1;
          else if (DRAW_REQ)                      draw_gnt = 1'b1;
        end
        CLEAR: begin
          if (DISP_REQ) disp_gnt  = 1'b1;
          else          clear_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve <= '0;
    end else if (state == ARB) begin
      if (!DRAW_REQ || draw_gnt)  starve <= '0;
      else if (starve != STARVE_MAX) starve <= starve + 1'b1;
    end
  end

  // The clear address parks on the last byte; it is re-zeroed on the next start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clear_addr  <= '0;
      clear_value <= '0;
      clear_done  <= 1'b0;
    end else begin
      clear_done <= clear_last;
      if ((state == ARB) && CLEAR_START) begin
        clear_addr  <= '0;
        clear_value <= CLEAR_VALUE;
      end else if (clear_gnt && !clear_last) begin
        clear_addr <= clear_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VRAM_ADDR <= '0;
      VRAM_DATA <= '0;
      VRAM_WE   <= 1'b0;
    end else begin
      VRAM_WE <= 1'b0;
      if (disp_gnt) begin
        VRAM_ADDR <= DISP_ADDR;
      end else if (draw_gnt) begin
        VRAM_ADDR <= DRAW_ADDR;
        VRAM_WE   <= DRAW_WE;
        if (DRAW_WE) VRAM_DATA <= DRAW_DATA;
      end else if (clear_gnt) begin
        VRAM_ADDR <= clear_addr;
        VRAM_DATA <= clear_value;
        VRAM_WE   <= 1'b1;
      end
    end
  end

  // Two-stage owner tag matches the port register plus the VRAM's registered read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_s1 <= 2'b00;
      tag_s2 <= 2'b00;
    end else begin
      tag_s1 <= {disp_gnt, draw_gnt && !DRAW_WE};
      tag_s2 <= tag_s1;
    end
  end

  assign DISP_GNT    = disp_gnt;
  assign DRAW_GNT    = draw_gnt;
  assign DISP_RVALID = tag_s2[1];
  assign DRAW_RVALID = tag_s2[0];
  assign DISP_RDATA  = tag_s2[1] ? VRAM_Q : 8'h00;
  assign DRAW_RDATA  = tag_s2[0] ? VRAM_Q : 8'h00;
  assign CLEAR_BUSY  = (state == CLEAR);
  assign CLEAR_DONE  = clear_done;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a small frame and a registered-read VRAM model.
module tb_vram_port_arbiter;
  localparam int TOTAL  = 64;
  localparam int ADDR_W = 18;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              DISP_REQ = 1'b0;
  logic [ADDR_W-1:0] DISP_ADDR = '0;
  logic              DISP_GNT, DISP_RVALID;
  logic [7:0]        DISP_RDATA;
  logic              DRAW_REQ = 1'b0, DRAW_WE = 1'b0;
  logic [ADDR_W-1:0] DRAW_ADDR = '0;
  logic [7:0]        DRAW_DATA = '0;
  logic              DRAW_GNT, DRAW_RVALID;
  logic [7:0]        DRAW_RDATA;
  logic              CLEAR_START = 1'b0;
  logic [7:0]        CLEAR_VALUE = '0;
  logic              CLEAR_BUSY, CLEAR_DONE;
  logic [ADDR_W-1:0] VRAM_ADDR;
  logic [7:0]        VRAM_DATA;
  logic              VRAM_WE;
  logic [7:0]        vram_q = '0;

  logic [7:0] mem [0:TOTAL-1];
  logic [7:0] exp_disp_q [$];
  logic [7:0] exp_draw_q [$];
  int n_compared   = 0;
  int n_mismatched = 0;

  vram_port_arbiter #(.TOTAL_BYTES(TOTAL), .ADDR_W(ADDR_W), .STARVE_LIMIT(15), .STARVE_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_GNT(DISP_GNT),
    .DISP_RVALID(DISP_RVALID), .DISP_RDATA(DISP_RDATA),
    .DRAW_REQ(DRAW_REQ), .DRAW_WE(DRAW_WE), .DRAW_ADDR(DRAW_ADDR), .DRAW_DATA(DRAW_DATA),
    .DRAW_GNT(DRAW_GNT), .DRAW_RVALID(DRAW_RVALID), .DRAW_RDATA(DRAW_RDATA),
    .CLEAR_START(CLEAR_START), .CLEAR_VALUE(CLEAR_VALUE),
    .CLEAR_BUSY(CLEAR_BUSY), .CLEAR_DONE(CLEAR_DONE),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .VRAM_WE(VRAM_WE), .VRAM_Q(vram_q)
  );

  always #5 CLK = ~CLK;

  initial for (int i = 0; i < TOTAL; i++) mem[i] <= 8'(i) ^ 8'h5A;

  always @(posedge CLK) begin
    if (VRAM_WE) mem[VRAM_ADDR[5:0]] <= VRAM_DATA;
    vram_q <= mem[VRAM_ADDR[5:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every returned read must match the oldest outstanding expectation of its owner.
  always @(negedge CLK) begin
    if (DISP_RVALID) begin
      if (exp_disp_q.size() == 0) checkOutput("disp_rvalid_unexpected", 1, 0);
      else                        checkOutput("disp_rdata", DISP_RDATA, exp_disp_q.pop_front());
    end
    if (DRAW_RVALID) begin
      if (exp_draw_q.size() == 0) checkOutput("draw_rvalid_unexpected", 1, 0);
      else                        checkOutput("draw_rdata", DRAW_RDATA, exp_draw_q.pop_front());
    end
  end

  task automatic applyStimulus(input logic d_req, input logic [ADDR_W-1:0] d_addr,
                               input logic w_req, input logic w_we, input logic [ADDR_W-1:0] w_addr,
                               input logic [7:0] w_data, input logic exp_dg, input logic exp_wg,
                               input logic [7:0] exp_data, input string name);
    DISP_REQ = d_req; DISP_ADDR = d_addr;
    DRAW_REQ = w_req; DRAW_WE = w_we; DRAW_ADDR = w_addr; DRAW_DATA = w_data;
    @(negedge CLK);
    checkOutput({name, "_disp_gnt"}, DISP_GNT, exp_dg);
    checkOutput({name, "_draw_gnt"}, DRAW_GNT, exp_wg);
    if (exp_dg)            exp_disp_q.push_back(exp_data);
    if (exp_wg && !w_we)   exp_draw_q.push_back(exp_data);
    @(posedge CLK); #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, '0, 8'h00, 0, 0, 8'h00, "idle");
  endtask

  // Full clear; display reads of the last byte on every 4th cycle up to disp_until.
  task automatic runClear(input logic [7:0] value, input int disp_until, input int exp_done, input string name);
    int done_at, dones, draw_gnts, we_count, bad;
    done_at = 0; dones = 0; draw_gnts = 0; we_count = 0; bad = 0;
    CLEAR_START = 1'b1; CLEAR_VALUE = value;
    @(negedge CLK); @(posedge CLK); #1;
    CLEAR_START = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      DISP_REQ  = ((cyc % 4) == 0) && (cyc <= disp_until);
      DISP_ADDR = ADDR_W'(TOTAL - 1);
      DRAW_REQ  = (disp_until > 0) && (cyc <= 70);
      DRAW_WE   = 1'b0; DRAW_ADDR = ADDR_W'(5);
      CLEAR_START = (cyc == 10);
      CLEAR_VALUE = (cyc == 10) ? 8'h77 : value;
      @(negedge CLK);
      if (cyc == 1) checkOutput({name, "_busy"}, CLEAR_BUSY, 1);
      if (DISP_REQ) begin
        checkOutput({name, "_disp_gnt"}, DISP_GNT, 1);
        exp_disp_q.push_back(8'h3C);
      end
      if (DRAW_GNT) draw_gnts++;
      if (VRAM_WE)  we_count++;
      if (CLEAR_DONE) begin
        dones++;
        if (done_at == 0) done_at = cyc;
      end
      @(posedge CLK); #1;
      if ((done_at != 0) && (cyc >= done_at + 3)) break;
    end
    DISP_REQ = 1'b0; DRAW_REQ = 1'b0; CLEAR_START = 1'b0;
    for (int i = 0; i < TOTAL; i++) if (mem[i] !== value) bad++;
    checkOutput({name, "_done_cycle"}, done_at, exp_done);
    checkOutput({name, "_done_count"}, dones, 1);
    checkOutput({name, "_write_count"}, we_count, TOTAL);
    checkOutput({name, "_draw_gnts"}, draw_gnts, 0);
    checkOutput({name, "_fill_errors"}, bad, 0);
    checkOutput({name, "_busy_after"}, CLEAR_BUSY, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rv_count, done_count;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_outputs", {DISP_GNT, DISP_RVALID, DISP_RDATA, DRAW_GNT, DRAW_RVALID,
                                  DRAW_RDATA, CLEAR_BUSY, CLEAR_DONE, VRAM_WE, VRAM_DATA}, 0);
    checkOutput("reset_vram_addr", VRAM_ADDR, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Display beats draw at starve 0; each read returns two cycles after its grant.
    applyStimulus(1, 18'h5, 1, 0, 18'h9, 8'h00, 1, 0, 8'h5F, "t1_a");
    applyStimulus(0, 18'h0, 1, 0, 18'h9, 8'h00, 0, 1, 8'h53, "t1_b");
    checkOutput("t1_disp_rvalid_n2", DISP_RVALID, 1);
    idleCycles(1);
    checkOutput("t1_draw_rvalid_n2", DRAW_RVALID, 1);
    idleCycles(3);

    // Fifteen denials, forced draw grant on the 16th cycle, display back on the 17th.
    for (int k = 1; k <= 17; k++)
      applyStimulus(1, 18'h21, k <= 16, 0, 18'h14, 8'h00, k != 16, k == 16,
                    (k == 16) ? 8'h4E : 8'h7B, "t2");
    idleCycles(3);

    applyStimulus(0, 18'h0, 1, 1, 18'h10, 8'hA5, 0, 1, 8'h00, "t3_wr");
    checkOutput("t3_we_n1", VRAM_WE, 1);
    checkOutput("t3_addr_n1", VRAM_ADDR, 18'h10);
    checkOutput("t3_data_n1", VRAM_DATA, 8'hA5);
    applyStimulus(0, 18'h0, 1, 0, 18'h10, 8'h00, 0, 1, 8'hA5, "t3_rd");
    checkOutput("t3_we_pulse", VRAM_WE, 0);
    idleCycles(3);

    runClear(8'h3C, 0, TOTAL + 1, "t4");
    idleCycles(2);
    runClear(8'hC3, 40, TOTAL + 11, "t5");
    idleCycles(3);

    // Reset mid-clear with a display read in flight.
    CLEAR_START = 1'b1; CLEAR_VALUE = 8'h11;
    @(negedge CLK); @(posedge CLK); #1;
    CLEAR_START = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    DISP_REQ = 1'b1; DISP_ADDR = 18'h7;
    @(negedge CLK);
    checkOutput("t6_disp_gnt", DISP_GNT, 1);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t6_outputs_zero", {DISP_GNT, DISP_RVALID, DISP_RDATA, DRAW_GNT, DRAW_RVALID,
                                    DRAW_RDATA, CLEAR_BUSY, CLEAR_DONE, VRAM_WE, VRAM_DATA}, 0);
    checkOutput("t6_vram_addr_zero", VRAM_ADDR, 0);
    exp_disp_q.delete();
    exp_draw_q.delete();
    DISP_REQ = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    rv_count = 0; done_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DISP_RVALID || DRAW_RVALID) rv_count++;
      if (CLEAR_DONE) done_count++;
    end
    checkOutput("t6_rvalid_after", rv_count, 0);
    checkOutput("t6_done_after", done_count, 0);
    checkOutput("t6_busy_after", CLEAR_BUSY, 0);

    checkOutput("disp_queue_empty", exp_disp_q.size(), 0);
    checkOutput("draw_queue_empty", exp_draw_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
